// File: rtl/latency_ram.sv
// Word-organised RAM with a fixed, parameterised response latency and a one-cycle
// ready pulse. Out-of-range requests complete with err=1 and never touch memory.
module latency_ram #(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic [3:0]  wstrb,
    output logic [31:0] dout,
    output logic        ready,
    output logic        err
);

    localparam int         DEPTH = 2 ** (ADDR_BITS - 2);
    localparam int         IW    = ADDR_BITS - 2;
    localparam logic [7:0] LAT_C = 8'(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q;
    logic [7:0]     cnt_q;
    logic [31:2]    addr_q;
    logic [31:0]    din_q;
    logic [3:0]     wstrb_q;
    logic [31:0]    dout_q;
    logic           ready_q;
    logic           err_q;
    logic [31:0]    mem [DEPTH];

    logic [31:2]    req_addr_s;
    logic [31:0]    req_din_s;
    logic [3:0]     req_wstrb_s;
    logic           oor_s;
    logic [IW-1:0]  idx_s;
    logic           enter_done_s;
    logic           wr_en_s;
    logic [31:0]    rd_word_s;
    logic [31:0]    wr_word_d;
    logic           unused_addr_s;

    assign unused_addr_s = ^addr[1:0];

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

    // Request view: live inputs in IDLE (LATENCY=0 completes at capture), captured copy otherwise.
    always_comb begin
        if (state_q == IDLE) begin
            req_addr_s  = addr[31:2];
            req_din_s   = din;
            req_wstrb_s = wstrb;
        end else begin
            req_addr_s  = addr_q;
            req_din_s   = din_q;
            req_wstrb_s = wstrb_q;
        end
        oor_s = (req_addr_s[31:ADDR_BITS] != '0);
        idx_s = req_addr_s[ADDR_BITS-1:2];
        case (state_q)
            IDLE:    enter_done_s = valid && (LAT_C == 8'd0);
            WAIT:    enter_done_s = valid && (cnt_q == 8'd1);
            default: enter_done_s = 1'b0;
        endcase
        rd_word_s = mem[idx_s];
        wr_en_s   = enter_done_s && !oor_s && (req_wstrb_s != 4'd0);
        wr_word_d = merge_bytes(rd_word_s, req_din_s, req_wstrb_s);
    end

    // Storage is deliberately unreset; a write only happens on the edge entering DONE.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[idx_s] <= wr_word_d;
        end
    end

    // Control FSM with registered ready/err/dout.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            addr_q  <= 30'd0;
            din_q   <= 32'd0;
            wstrb_q <= 4'd0;
            dout_q  <= 32'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid) begin
                        addr_q  <= addr[31:2];
                        din_q   <= din;
                        wstrb_q <= wstrb;
                        cnt_q   <= LAT_C;
                        state_q <= (LAT_C == 8'd0) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    // A dropped valid here is a protocol violation: abandon silently.
                    if (!valid) begin
                        cnt_q   <= 8'd0;
                        state_q <= IDLE;
                    end else begin
                        if (cnt_q != 8'd0) begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                        if (cnt_q == 8'd1) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            if (enter_done_s) begin
                ready_q <= 1'b1;
                err_q   <= oor_s;
                dout_q  <= oor_s ? 32'd0 : rd_word_s;
            end else begin
                ready_q <= 1'b0;
            end
        end
    end

    assign dout  = dout_q;
    assign ready = ready_q;
    assign err   = err_q;

endmodule

// File: tb/tb_latency_ram.sv
// Directed bench for latency_ram: a LATENCY=2 instance driven from a vector table
// plus corner sequences, and a LATENCY=0 instance for back-to-back traffic.
module tb_latency_ram;

    localparam int LAT = 2;

    logic        clk;
    logic        resetn;
    logic        valid, valid0;
    logic [31:0] addr, addr0, din, din0;
    logic [3:0]  wstrb, wstrb0;
    logic [31:0] dout, dout0;
    logic        ready, ready0, err, err0;

    int n_tests;
    int n_fail;

    latency_ram #(.ADDR_BITS(10), .LATENCY(LAT)) dut (
        .clk(clk), .resetn(resetn), .valid(valid), .addr(addr), .din(din),
        .wstrb(wstrb), .dout(dout), .ready(ready), .err(err)
    );

    latency_ram #(.ADDR_BITS(10), .LATENCY(0)) dut0 (
        .clk(clk), .resetn(resetn), .valid(valid0), .addr(addr0), .din(din0),
        .wstrb(wstrb0), .dout(dout0), .ready(ready0), .err(err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic        chk_dout;
        logic [31:0] exp_dout;
        logic        exp_err;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One request on the LATENCY=2 instance; optionally scrambles inputs during WAIT.
    task automatic run_req(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic scramble,
                           output logic [31:0] rd, output logic re);
        int lat;
        lat = 0;
        @(negedge clk);
        valid = 1'b1; addr = a; din = d; wstrb = s;
        do begin
            @(posedge clk); #1;
            lat++;
            if (scramble && lat == 1) begin
                addr = a ^ 32'h0000_0030; din = ~d; wstrb = ~s;
            end
        end while (!ready && lat < 20);
        rd = dout;
        re = err;
        check({tag, "_latency"}, 32'(lat), 32'(LAT + 1));
        valid = 1'b0; addr = 32'd0; din = 32'd0; wstrb = 4'd0;
        @(posedge clk); #1;
        check({tag, "_pulse_width"}, {31'd0, ready}, 32'd0);
        check({tag, "_dout_hold"}, dout, rd);
        check({tag, "_err_hold"}, {31'd0, err}, {31'd0, re});
    endtask

    logic [31:0] rd;
    logic        re;
    int          cnt;

    initial begin
        n_tests = 0; n_fail = 0;
        resetn = 1'b0;
        valid = 1'b0; addr = 32'd0; din = 32'd0; wstrb = 4'd0;
        valid0 = 1'b0; addr0 = 32'd0; din0 = 32'd0; wstrb0 = 4'd0;

        tbl[0]  = '{32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0000_0000, 1'b0};
        tbl[1]  = '{32'h0000_0010, 32'h0000_0000, 4'h0, 1'b1, 32'hDEAD_BEEF, 1'b0};
        tbl[2]  = '{32'h0000_0020, 32'h1122_3344, 4'hF, 1'b0, 32'h0000_0000, 1'b0};
        tbl[3]  = '{32'h0000_0020, 32'hAABB_CCDD, 4'h5, 1'b1, 32'h1122_3344, 1'b0};
        tbl[4]  = '{32'h0000_0020, 32'h0000_0000, 4'h0, 1'b1, 32'h11BB_33DD, 1'b0};
        tbl[5]  = '{32'h0000_0000, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0000_0000, 1'b0};
        tbl[6]  = '{32'h0000_0400, 32'h0000_0000, 4'h0, 1'b1, 32'h0000_0000, 1'b1};
        tbl[7]  = '{32'h0000_0400, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0000_0000, 1'b1};
        tbl[8]  = '{32'h0000_0000, 32'h0000_0000, 4'h0, 1'b1, 32'hCAFE_F00D, 1'b0};
        tbl[9]  = '{32'h0000_0013, 32'h0000_0000, 4'h0, 1'b1, 32'hDEAD_BEEF, 1'b0};
        tbl[10] = '{32'h0000_0030, 32'h1234_5678, 4'hF, 1'b0, 32'h0000_0000, 1'b0};
        tbl[11] = '{32'h8000_0004, 32'h0000_0000, 4'h0, 1'b1, 32'h0000_0000, 1'b1};
        tbl[12] = '{32'h0000_0030, 32'h0000_0000, 4'h0, 1'b1, 32'h1234_5678, 1'b0};
        tbl[13] = '{32'h0000_0040, 32'h0BAD_F00D, 4'hF, 1'b0, 32'h0000_0000, 1'b0};

        #2;
        check("reset_ready", {31'd0, ready}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_dout", dout, 32'd0);
        check("reset_ready0", {31'd0, ready0}, 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_req($sformatf("vec%0d", i), tbl[i].a, tbl[i].d, tbl[i].s, 1'b0, rd, re);
            if (tbl[i].chk_dout) check($sformatf("vec%0d_dout", i), rd, tbl[i].exp_dout);
            check($sformatf("vec%0d_err", i), {31'd0, re}, {31'd0, tbl[i].exp_err});
        end

        // Inputs changed during WAIT must be ignored.
        run_req("scr_wr", 32'h0000_0010, 32'h0102_0304, 4'hF, 1'b1, rd, re);
        run_req("scr_rd10", 32'h0000_0010, 32'd0, 4'h0, 1'b0, rd, re);
        check("scr_rd10_dout", rd, 32'h0102_0304);
        run_req("scr_rd20", 32'h0000_0020, 32'd0, 4'h0, 1'b0, rd, re);
        check("scr_rd20_dout", rd, 32'h11BB_33DD);

        // Reset in the middle of a write to 0x30.
        @(negedge clk);
        valid = 1'b1; addr = 32'h0000_0030; din = 32'hFFFF_FFFF; wstrb = 4'hF;
        @(posedge clk); #3;
        resetn = 1'b0;
        #1;
        check("rst_mid_ready", {31'd0, ready}, 32'd0);
        check("rst_mid_err", {31'd0, err}, 32'd0);
        check("rst_mid_dout", dout, 32'd0);
        valid = 1'b0; addr = 32'd0; din = 32'd0; wstrb = 4'd0;
        cnt = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (ready) cnt++;
        end
        check("rst_no_pulse", 32'(cnt), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        run_req("rst_rd30", 32'h0000_0030, 32'd0, 4'h0, 1'b0, rd, re);
        check("rst_rd30_dout", rd, 32'h1234_5678);

        // valid dropped during WAIT aborts the write to 0x40.
        @(negedge clk);
        valid = 1'b1; addr = 32'h0000_0040; din = 32'hFFFF_FFFF; wstrb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0; addr = 32'd0; din = 32'd0; wstrb = 4'd0;
        cnt = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (ready) cnt++;
        end
        check("abort_no_pulse", 32'(cnt), 32'd0);
        run_req("abort_rd40", 32'h0000_0040, 32'd0, 4'h0, 1'b0, rd, re);
        check("abort_rd40_dout", rd, 32'h0BAD_F00D);

        // LATENCY=0, valid held high: write 0x04, write 0x08, read 0x04, read 0x08.
        @(negedge clk);
        valid0 = 1'b1; addr0 = 32'h0000_0004; din0 = 32'hA5A5_A5A5; wstrb0 = 4'hF;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("l0_op%0d_ready", k), {31'd0, ready0}, 32'd1);
            if (k >= 2) begin
                check($sformatf("l0_op%0d_dout", k), dout0,
                      (k == 2) ? 32'hA5A5_A5A5 : 32'h5A5A_5A5A);
                check($sformatf("l0_op%0d_err", k), {31'd0, err0}, 32'd0);
            end
            case (k)
                0:       begin addr0 = 32'h0000_0008; din0 = 32'h5A5A_5A5A; end
                1:       begin addr0 = 32'h0000_0004; wstrb0 = 4'h0; end
                2:       addr0 = 32'h0000_0008;
                default: valid0 = 1'b0;
            endcase
            @(posedge clk); #1;
            check($sformatf("l0_op%0d_gap", k), {31'd0, ready0}, 32'd0);
        end
        @(posedge clk); #1;
        check("l0_idle", {31'd0, ready0}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/latency_ram.md
LATENCY_RAM -- requirements
Module: latency_ram

Interface
REQ-001 Parameter ADDR_BITS, default 10: byte-address width decoded; depth 2**(ADDR_BITS-2) 32-bit words; legal range 3..24.
REQ-002 Parameter LATENCY, default 2: wait cycles inserted before response; legal range 0..255.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port resetn  input  1  reset, asynchronous, active-low.
REQ-005 Port valid  input  1  request present; held high with addr/din/wstrb stable until ready sampled high.
REQ-006 Port addr  input  32  byte address; bits [ADDR_BITS-1:2] select word, bits [1:0] ignored.
REQ-007 Port din  input  32  write data.
REQ-008 Port wstrb  input  4  byte write enables; 4'b0000 = read.
REQ-009 Port dout  output  32  registered read data, meaningful while ready=1.
REQ-010 Port ready  output  1  registered one-cycle completion pulse.
REQ-011 Port err  output  1  registered; high with ready when the request was out of range.

Function
REQ-012 FSM states SHALL be IDLE, WAIT, DONE; ready=1 only in DONE.
REQ-013 IDLE: valid=1 at an edge -> capture addr, din, wstrb, load wait counter with LATENCY, go WAIT (LATENCY>0) or DONE (LATENCY=0).
REQ-014 WAIT: counter decrements by 1 per edge; on the edge where it reaches 0 -> DONE.
REQ-015 Response latency: valid first sampled at edge N -> ready high during the cycle after edge N+LATENCY, for exactly one cycle.
REQ-016 DONE -> IDLE unconditionally at next edge; a valid high in the following cycle is a new request (back-to-back allowed, no idle gap required).
REQ-017 Out-of-range: captured addr[31:ADDR_BITS] nonzero -> no write, dout=0, err=1 during DONE.
REQ-018 In-range read (wstrb=0): dout = word at captured index, loaded on the edge entering DONE; err=0.
REQ-019 In-range write: on the edge entering DONE, each byte lane i with wstrb[i]=1 takes din lane i, other lanes keep old value; dout = pre-write word.
REQ-020 Write visibility: a request issued immediately after a write completes SHALL observe the written data.
REQ-021 valid dropping to 0 while in WAIT (protocol violation) SHALL abort: return to IDLE next edge, no write, no ready, no err.
REQ-022 Request inputs changing during WAIT SHALL be ignored; only captured values are used.
REQ-023 dout and err SHALL hold their last value outside DONE; err cleared to 0 on every in-range completion.
REQ-024 Wait counter width SHALL be sufficient for LATENCY (8 bits suffices); no wrap below 0.

Reset
REQ-025 resetn=0 SHALL immediately force state IDLE, ready=0, err=0, dout=0, counter=0, independent of clk.
REQ-026 Reset asserted mid-transaction SHALL abandon it with no memory write; memory contents are not cleared and are undefined after power-up.
REQ-027 First request is accepted at the first rising edge with resetn=1 and valid=1.

Verification
REQ-028 LATENCY=2: write addr 0x10, din 0xDEADBEEF, wstrb 4'hF at edge N -> ready=1 in cycle after edge N+2 only; then read 0x10 -> dout 0xDEADBEEF, err 0.
REQ-029 Partial write: word 0x11223344 at 0x20, then write din 0xAABBCCDD wstrb 4'b0101 -> read returns 0x11BB33DD; write-response dout 0x11223344.
REQ-030 ADDR_BITS=10: read/write addr 0x400 -> err=1, dout=0, ready pulse at normal latency; word 0x000 unchanged.
REQ-031 LATENCY=0: back-to-back reads of 0x04 and 0x08 with valid held high -> ready pulses on alternate cycles, correct data each.
REQ-032 Reset: assert resetn=0 during WAIT of a write to 0x30 -> ready, err, dout go 0 immediately, no ready pulse; post-reset read of 0x30 returns pre-write contents.
REQ-033 Abort: drop valid during WAIT of write to 0x40 -> no ready pulse, word 0x40 unchanged, next request completes normally.
